// File: rtl/common.sv
// Shared types for the execute stage: M-extension op codes, sequencer states
// and the decoded control word that carries is_muldiv into EX.
package common;

  typedef enum logic [2:0] {
    MUL    = 3'd0,
    MULH   = 3'd1,
    MULHSU = 3'd2,
    MULHU  = 3'd3,
    DIV    = 3'd4,
    DIVU   = 3'd5,
    REM    = 3'd6,
    REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  // is_muldiv is routed to the sequencer start input while the instruction is in EX.
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic is_muldiv;
  } control_type;

  function automatic logic op_is_div(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulator, shift-add / restoring-divide step and final sign fix-up for the
// RV32M sequencer. Operands are held as magnitudes; sign is restored in FIX.
module muldiv_datapath
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            load,
  input  logic            step,
  input  logic            commit,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  output logic            special,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_op_t        op_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   opnd_q;
  logic              neg_q;
  logic              special_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   a_mag, b_mag, special_val;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN-1:0]   rem_diff;
  logic              rem_ge;
  logic [2*XLEN-1:0] mul_next, div_next, prod;
  logic [XLEN-1:0]   fix_val;

  function automatic logic [XLEN-1:0] negate(input logic [XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  function automatic logic [2*XLEN-1:0] negate_wide(input logic [2*XLEN-1:0] v);
    return ~v + 1'b1;
  endfunction

  // Operand decode at acceptance
  always_comb begin
    a_signed = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    b_signed = (op == MULH) || (op == DIV) || (op == REM);
    a_neg    = a_signed & operand_a[XLEN-1];
    b_neg    = b_signed & operand_b[XLEN-1];
    a_mag    = a_neg ? negate(operand_a) : operand_a;
    b_mag    = b_neg ? negate(operand_b) : operand_b;
    div_zero = op_is_div(op) && (operand_b == '0);
    div_ovf  = ((op == DIV) || (op == REM)) && (operand_a == MIN_NEG) && (operand_b == '1);
    special  = div_zero | div_ovf;
    if ((op == REM) || (op == REMU)) begin
      special_val = div_zero ? operand_a : '0;
    end else begin
      special_val = div_zero ? '1 : MIN_NEG;
    end
  end

  // Iteration step: multiply keeps {partial product, multiplier}, divide keeps {remainder, quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    rem_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_ge    = rem_shift >= {1'b0, opnd_q};
    rem_diff  = rem_shift[XLEN-1:0] - opnd_q;
    div_next  = {(rem_ge ? rem_diff : rem_shift[XLEN-1:0]), acc_q[XLEN-2:0], rem_ge};
  end

  // FIX stage: sign restore and result select
  always_comb begin
    prod    = neg_q ? negate_wide(acc_q) : acc_q;
    fix_val = prod[XLEN-1:0];
    case (op_q)
      MUL:                  fix_val = prod[XLEN-1:0];
      MULH, MULHSU, MULHU:  fix_val = prod[2*XLEN-1:XLEN];
      DIV, DIVU:            fix_val = neg_q ? negate(acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
      REM, REMU:            fix_val = neg_q ? negate(acc_q[2*XLEN-1:XLEN]) : acc_q[2*XLEN-1:XLEN];
      default:              fix_val = prod[XLEN-1:0];
    endcase
    if (special_q) begin
      fix_val = acc_q[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q      <= MUL;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      special_q <= 1'b0;
      result    <= '0;
    end else begin
      if (load) begin
        op_q      <= op;
        special_q <= special;
        neg_q     <= ((op == REM) || (op == REMU)) ? a_neg : (a_neg ^ b_neg);
        if (special) begin
          acc_q <= {{XLEN{1'b0}}, special_val};
        end else if (op_is_div(op)) begin
          acc_q  <= {{XLEN{1'b0}}, a_mag};
          opnd_q <= b_mag;
        end else begin
          acc_q  <= {{XLEN{1'b0}}, b_mag};
          opnd_q <= a_mag;
        end
      end else if (step) begin
        acc_q <= op_is_div(op_q) ? div_next : mul_next;
      end
      if (commit) begin
        result <= fix_val;
      end
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, iteration counter and pipeline
// handshake around muldiv_datapath. Result is valid in the single done cycle.
module muldiv_sequencer
  import common::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  muldiv_op_t      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int              CNT_W    = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             done_q;
  logic             accept, step, commit, special;

  // A start seen while done is high is the retiring instruction, not a new one.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    step    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !flush && !done_q) begin
          accept  = 1'b1;
          count_d = CNT_LAST;
          state_d = special ? FIX : CALC;
        end
      end
      CALC: begin
        step    = !flush;
        count_d = count_q - 1'b1;
        if (count_q == '0) begin
          state_d = FIX;
        end
      end
      FIX: begin
        commit  = !flush;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= commit;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign stall = (start & ~done_q) | busy;

  muldiv_datapath #(
    .XLEN (XLEN)
  ) u_datapath (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (accept),
    .step      (step),
    .commit    (commit),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .special   (special),
    .result    (result)
  );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed RV32M cases with literal results plus a
// randomized run checked every cycle against an arithmetic reference model.
module tb_muldiv_sequencer;
  import common::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  muldiv_op_t  op = MUL;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        stall, busy, done;
  logic [31:0] result;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .result    (result)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic straight from the RV32M definitions.
  function automatic logic [31:0] ref_result(input muldiv_op_t o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint      sa, sb, ub, p;
    logic [63:0] pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    pu = {32'b0, a} * {32'b0, b};
    case (o)
      MUL:    begin p = sa * sb; return p[31:0]; end
      MULH:   begin p = sa * sb; return p[63:32]; end
      MULHSU: begin p = sa * ub; return p[63:32]; end
      MULHU:  return pu[63:32];
      DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      REM: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b);
    if (!o[2]) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return ((o == DIV) || (o == REM)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  endfunction

  // Behavioural model: cycles remaining until done, pending result, retired result.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  int          m_left = 0;
  bit          m_nd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_res  = '0;
      m_left = 0;
    end else begin
      m_nd = 1'b0;
      if (m_busy) begin
        if (flush) begin
          m_busy = 1'b0;
        end else begin
          m_left--;
          if (m_left == 0) begin
            m_busy = 1'b0;
            m_nd   = 1'b1;
            m_res  = m_pend;
          end
        end
      end else if (start && !flush && !m_done) begin
        m_pend = ref_result(op, operand_a, operand_b);
        m_left = (is_special(op, operand_a, operand_b) ? 2 : 34) - 1;
        m_busy = 1'b1;
      end
      m_done = m_nd;
    end
  end

  always @(negedge clk) begin
    if (done) n_done++;
    check("cyc_done", {31'b0, done}, {31'b0, m_done});
    check("cyc_busy", {31'b0, busy}, {31'b0, m_busy});
    check("cyc_stall", {31'b0, stall}, {31'b0, (start & ~m_done) | m_busy});
    check("cyc_result", result, m_res);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
    end
  endtask

  // Presents one instruction and holds start until its done cycle.
  task automatic run_op(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string name);
    int c;
    int nst;
    bit got;
    c = 0;
    nst = 0;
    got = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    flush = 1'b0;
    op = o;
    operand_a = a;
    operand_b = b;
    while (!got && c < 80) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
      end else begin
        if (stall) nst++;
        c++;
        @(posedge clk); #1;
      end
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_latency"}, c, lat);
    check({name, "_stall_cycles"}, nst, lat);
    check({name, "_result"}, result, exp);
    check({name, "_model"}, m_res, exp);
  endtask

  function automatic logic [31:0] pick_operand();
    logic [31:0] v;
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = 32'h8000_0000;
      2:       v = 32'hFFFF_FFFF;
      3:       v = $urandom_range(0, 20);
      default: v = $urandom();
    endcase
    return v;
  endfunction

  initial begin
    int  d0;
    bit  holding;
    bit  was_done;
    int  w;

    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_stall_follows_start_hi", {31'b0, stall}, 32'd1);
    start = 1'b0;
    #1;
    check("rst_stall_follows_start_lo", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(2);

    d0 = n_done;
    run_op(MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul_7x-3");
    run_op(MUL, 32'd2, 32'd3, 32'd6, 34, "mul_b2b_2x3");
    idle(1);
    check("b2b_done_pulses", n_done - d0, 32'd2);

    run_op(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu_ff"); idle(1);
    run_op(MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 34, "mulh_ff");  idle(1);
    run_op(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu_ff"); idle(1);
    run_op(DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, "div_-7_2"); idle(1);
    run_op(REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, "rem_-7_2"); idle(1);
    run_op(DIVU, 32'd100, 32'd7, 32'd14, 34, "divu_100_7"); idle(1);
    run_op(REMU, 32'd100, 32'd7, 32'd2, 34, "remu_100_7"); idle(1);
    run_op(DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, 2, "div_by_zero"); idle(1);
    run_op(REM,  32'd5, 32'd0, 32'd5, 2, "rem_by_zero"); idle(1);
    run_op(DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2, "div_ovf"); idle(1);
    run_op(REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2, "rem_ovf"); idle(1);
    run_op(REMU, 32'd100, 32'd7, 32'd2, 34, "remu_pre_flush"); idle(1);

    // Flush in the tenth CALC cycle
    @(posedge clk); #1;
    start = 1'b1;
    op = DIVU;
    operand_a = 32'd1000;
    operand_b = 32'd7;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    start = 1'b0;
    d0 = n_done;
    @(negedge clk);
    check("flush_cycle_busy", {31'b0, busy}, 32'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy_cleared", {31'b0, busy}, 32'd0);
    check("flush_no_done", {31'b0, done}, 32'd0);
    check("flush_result_kept", result, 32'd2);
    idle(40);
    check("flush_no_late_done", n_done - d0, 32'd0);
    run_op(DIVU, 32'd9, 32'd3, 32'd3, 34, "divu_after_flush"); idle(1);

    // Asynchronous reset in the middle of CALC
    @(posedge clk); #1;
    start = 1'b1;
    op = MUL;
    operand_a = 32'd123;
    operand_b = 32'd456;
    repeat (8) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_stall", {31'b0, stall}, 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    d0 = n_done;
    idle(40);
    check("midrst_no_done", n_done - d0, 32'd0);

    // Randomized traffic: back-to-back, flushes, operand churn while busy
    holding = 1'b0;
    was_done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      if (holding && was_done) begin
        holding = 1'b0;
      end
      was_done = 1'b0;
      if (holding) begin
        if (m_done) begin
          was_done = 1'b1;
        end else if ($urandom_range(0, 59) == 0) begin
          flush = 1'b1;
          start = 1'b0;
          holding = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          op = muldiv_op_t'(3'($urandom_range(0, 7)));
          operand_a = pick_operand();
          operand_b = pick_operand();
        end
      end else if ($urandom_range(0, 2) != 0) begin
        holding = 1'b1;
        start = 1'b1;
        op = muldiv_op_t'(3'($urandom_range(0, 7)));
        operand_a = pick_operand();
        operand_b = pick_operand();
      end else begin
        start = 1'b0;
        flush = ($urandom_range(0, 19) == 0);
      end
    end

    start = 1'b0;
    flush = 1'b0;
    w = 0;
    while ((m_busy || m_done) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_idle", {31'b0, m_busy}, 32'd0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle RV32M multiply/divide sequencer beside the execute-stage ALU. When the execute stage holds an M-extension instruction, this block takes the operands, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline stalled until the result is ready. Its result is muxed onto the execute-stage ALU result path in the cycle `done` is high. It aborts cleanly when a branch flush kills the instruction.

## Interface

Parameters:
- `XLEN`, default 32: operand and result width.

Ports:
- `clk`, in, 1: the single clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: execute stage holds a valid M-extension instruction. Held high for as long as the instruction sits in EX.
- `op`, in, 3: RV32M funct3, encoded as `muldiv_op_t`.
- `operand_a`, in, XLEN: forwarded rs1 value.
- `operand_b`, in, XLEN: forwarded rs2 value.
- `flush`, in, 1: EX instruction is killed; abort.
- `stall`, out, 1: freezes IF/ID/EX. Combinational.
- `busy`, out, 1: FSM not in IDLE.
- `done`, out, 1: one-cycle pulse; `result` is valid in this cycle.
- `result`, out, XLEN: final value. Held until the next accepted start.

## Operation

FSM states:
- IDLE:
  - Accept when `start & ~flush & ~done`.
  - Latch `op`. Latch magnitudes of the operands, with signedness per `op`.
  - Latch the result-sign flag.
  - Load `count` with XLEN-1.
  - Divide by zero, or signed overflow (-2^31 / -1): go to FIX with the special result preloaded.
  - Otherwise: go to CALC.
- CALC, multiply: one shift-add step per cycle into a 2·XLEN accumulator.
- CALC, divide: one restoring step per cycle, producing a quotient bit and a partial remainder.
- CALC exit: when `count`==0, go to FIX. `count` decrements every cycle in CALC.
- FIX:
  - Apply two's-complement negation where required.
  - Select the result: low word for MUL, high word for MULH/MULHSU/MULHU, quotient for DIV/DIVU, remainder for REM/REMU.
  - Register `result`, pulse `done`, return to IDLE.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - DIV/REM: both signed.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
- Special results, fixed by the RISC-V spec:
  - DIV/DIVU by 0: all ones.
  - REM/REMU by 0: `operand_a`.
  - DIV overflow: 0x8000_0000.
  - REM overflow: 0.
- `stall = (start & ~done) | busy`.
- A `start` seen while `done` is high is the instruction being acknowledged. It is never a new request.
- `flush`, in any state: return to IDLE next edge. No `done` is produced, and `result` is unchanged.
- `flush` has priority over a FIX→done transition in the same cycle.
- `start` is ignored while busy. `op` and operands are sampled only at acceptance.

## Timing

- Reset (async, while `reset_n`=0):
  - State IDLE.
  - `count`, `result`, accumulators = 0.
  - `done`=0, `busy`=0.
  - `stall` follows `start`.
- Normal op, accept edge = E0:
  - CALC occupies cycles E0+1 … E0+32.
  - FIX is at E0+33.
  - `done`=1 in the cycle after E0+33, i.e. 34 cycles after acceptance.
- Special cases (div-by-zero, overflow): `done` 2 cycles after acceptance.
- `stall` is high from the first `start` cycle through the cycle before `done`. It is low in the `done` cycle, so the pipeline advances with `result` that cycle.
- Back-to-back M instructions:
  - The next instruction enters EX after the `done` cycle.
  - It is accepted at the following edge.
  - There is no dead cycle beyond that.
- Reset mid-operation: immediate return to IDLE. No `done` follows.

## Structure

- Add `muldiv_op_t` to package `common`: MUL=0, MULH=1, MULHSU=2, MULHU=3, DIV=4, DIVU=5, REM=6, REMU=7.
- Add `muldiv_state_t` (IDLE, CALC, FIX) to `common`.
- Add a new `control_type` field, `is_muldiv`, which drives `start`.
- One sub-module is natural: `muldiv_datapath`. It holds the accumulator, the shift/subtract step, and the negate/select logic. The top level holds the FSM, counter, and handshake.

## Test plan

- MUL 7×(-3) -> `done` at acceptance+34; result 0xFFFF_FFEB; `stall` high for exactly 34 cycles before `done`.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF -> 0xFFFF_FFFE. MULH of the same operands -> 0x0000_0000. MULHSU -> 0xFFFF_FFFF.
- DIV -7/2 -> 0xFFFF_FFFD. REM -7/2 -> 0xFFFF_FFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFF_FFFF and REM 5/0 -> 5, each with `done` at acceptance+2. DIV 0x8000_0000/-1 -> 0x8000_0000 and REM of the same -> 0, each at acceptance+2.
- `flush` at CALC cycle 10 -> IDLE next edge; no `done`; `result` keeps its prior value. A new DIVU 9/3 accepted afterwards -> 3.
- `reset_n` low mid-CALC -> `busy`, `done`, `result` = 0 immediately. `start` held across `done` followed by a second MUL 2×3 -> exactly two `done` pulses, with results 0x…(first) then 6.
